// File: rtl/alu_issue.sv
// alu_issue: single-slot issue stage in front of a combinational ALU.
// It decodes the ALU operation and registers the operands and control code
// toward the external ALU. Multiplies are held in EXEC for MUL_CYCLES cycles.
// The result is captured and handed downstream over a valid/ready handshake.
module alu_issue #(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  aluop_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    output logic [3:0]  alu_ctrl_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        error_o
);

    localparam logic [3:0] CTRL_AND     = 4'd0;
    localparam logic [3:0] CTRL_OR      = 4'd1;
    localparam logic [3:0] CTRL_ADD     = 4'd2;
    localparam logic [3:0] CTRL_MUL     = 4'd4;
    localparam logic [3:0] CTRL_SUB     = 4'd6;
    localparam logic [3:0] CTRL_SLT     = 4'd7;
    localparam logic [3:0] CTRL_PASS    = 4'd11;
    localparam logic [3:0] CTRL_ILLEGAL = 4'd15;

    // A multiply spends MUL_CYCLES cycles in EXEC, so the counter starts one lower.
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [3:0] dec_code;
    logic       accept;

    assign accept = valid_i & ready_o;

    // Decode the operation class and function field into the ALU control code.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; otherwise
        // any path that misses an assignment infers a latch.
        dec_code = CTRL_ILLEGAL;
        unique case (aluop_i)
            3'b000: dec_code = CTRL_ADD;
            3'b001: dec_code = CTRL_SUB;
            3'b011: dec_code = CTRL_SLT;
            3'b100: dec_code = CTRL_AND;
            3'b101: dec_code = CTRL_OR;
            3'b110: dec_code = CTRL_PASS;
            3'b111: dec_code = CTRL_ILLEGAL;
            3'b010: begin
                case (funct_i)
                    6'b100100: dec_code = CTRL_AND;
                    6'b100101: dec_code = CTRL_OR;
                    6'b100000: dec_code = CTRL_ADD;
                    6'b100010: dec_code = CTRL_SUB;
                    6'b101010: dec_code = CTRL_SLT;
                    6'b011000: dec_code = CTRL_MUL;
                    default:   dec_code = CTRL_ILLEGAL;
                endcase
            end
            default: dec_code = CTRL_ILLEGAL;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state is written with non-blocking assignments so that
        // every register samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a DONE with a waiting operation goes straight back to EXEC.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = EXEC;
            EXEC: if (cnt == 4'd0) state_next = DONE;
            DONE: begin
                if (ready_i) begin
                    state_next = valid_i ? EXEC : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        ready_o = (state == IDLE) | ((state == DONE) & ready_i);
        valid_o = (state == DONE);
    end

    // Operand/control capture on accept, multiply countdown and result capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt        <= 4'd0;
            alu_src1_o <= 32'd0;
            alu_src2_o <= 32'd0;
            alu_ctrl_o <= CTRL_ILLEGAL;
            result_o   <= 32'd0;
            zero_o     <= 1'b0;
            error_o    <= 1'b0;
        end else if (accept) begin
            alu_src1_o <= src1_i;
            alu_src2_o <= src2_i;
            alu_ctrl_o <= dec_code;
            cnt        <= (dec_code == CTRL_MUL) ? MUL_CNT_INIT : 4'd0;
        end else if (state == EXEC) begin
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else if (alu_ctrl_o == CTRL_ILLEGAL) begin
                // Illegal operations never trust the ALU: fixed zero result.
                result_o <= 32'd0;
                zero_o   <= 1'b1;
                error_o  <= 1'b1;
            end else begin
                result_o <= alu_result_i;
                zero_o   <= alu_zero_i;
                error_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: table-driven directed vectors, hand-written corner sequences
// (backpressure, back-to-back accept, reset during a multiply) and a random
// phase checked against an operation-level reference model.
module tb_alu_issue;

    localparam int MUL_CYCLES = 3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  aluop_i;
    logic [5:0]  funct_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [31:0] alu_src1_o;
    logic [31:0] alu_src2_o;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        error_o;

    int checks = 0;
    int errors = 0;

    alu_issue #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .aluop_i      (aluop_i),
        .funct_i      (funct_i),
        .src1_i       (src1_i),
        .src2_i       (src2_i),
        .alu_src1_o   (alu_src1_o),
        .alu_src2_o   (alu_src2_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .alu_result_i (alu_result_i),
        .alu_zero_i   (alu_zero_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result_o),
        .zero_o       (zero_o),
        .error_o      (error_o)
    );

    always #5 clk_i = ~clk_i;

    // External combinational ALU; an illegal code yields junk so that the
    // forced illegal response is actually observable.
    always_comb begin
        alu_result_i = 32'hBAD0_0BAD;
        case (alu_ctrl_o)
            4'd0:  alu_result_i = alu_src1_o & alu_src2_o;
            4'd1:  alu_result_i = alu_src1_o | alu_src2_o;
            4'd2:  alu_result_i = alu_src1_o + alu_src2_o;
            4'd4:  alu_result_i = alu_src1_o * alu_src2_o;
            4'd6:  alu_result_i = alu_src1_o - alu_src2_o;
            4'd7:  alu_result_i = {31'd0, $signed(alu_src1_o) < $signed(alu_src2_o)};
            4'd11: alu_result_i = alu_src1_o;
            default: alu_result_i = 32'hBAD0_0BAD;
        endcase
        alu_zero_i = (alu_result_i == 32'd0);
    end

    typedef struct {
        logic [2:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        int          stall;
        logic [3:0]  ctrl;
        logic [31:0] result;
        logic        zero;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] result;
        logic        zero;
        logic        err;
        int          lat;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model at the operation level: name the operation, then do the arithmetic.
    function automatic exp_t model(input logic [2:0] aluop, input logic [5:0] funct,
                                   input logic [31:0] a, input logic [31:0] b);
        typedef enum {OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_OR, OP_PASS, OP_MUL, OP_BAD} op_t;
        op_t  op;
        exp_t e;
        case (aluop)
            3'b000: op = OP_ADD;
            3'b001: op = OP_SUB;
            3'b011: op = OP_SLT;
            3'b100: op = OP_AND;
            3'b101: op = OP_OR;
            3'b110: op = OP_PASS;
            3'b010: begin
                case (funct)
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b101010: op = OP_SLT;
                    6'b011000: op = OP_MUL;
                    default:   op = OP_BAD;
                endcase
            end
            default: op = OP_BAD;
        endcase
        e.err = 1'b0;
        e.lat = 2;
        case (op)
            OP_ADD:  begin e.ctrl = 4'd2;  e.result = a + b; end
            OP_SUB:  begin e.ctrl = 4'd6;  e.result = a - b; end
            OP_SLT:  begin e.ctrl = 4'd7;  e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
            OP_AND:  begin e.ctrl = 4'd0;  e.result = a & b; end
            OP_OR:   begin e.ctrl = 4'd1;  e.result = a | b; end
            OP_PASS: begin e.ctrl = 4'd11; e.result = a; end
            OP_MUL:  begin e.ctrl = 4'd4;  e.result = a * b; e.lat = MUL_CYCLES + 1; end
            default: begin e.ctrl = 4'd15; e.result = 32'd0; e.err = 1'b1; end
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    // One complete transaction from IDLE back to IDLE; entered and left #1 after an edge.
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        valid_i = 1'b1;
        aluop_i = v.aluop;
        funct_i = v.funct;
        src1_i  = v.a;
        src2_i  = v.b;
        ready_i = (v.stall == 0);
        #1;
        check({tag, " ready_at_accept"}, {31'd0, ready_o}, 32'd1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        aluop_i = 3'($urandom);
        funct_i = 6'($urandom);
        src1_i  = $urandom;
        src2_i  = $urandom;
        check({tag, " ctrl"}, {28'd0, alu_ctrl_o}, {28'd0, v.ctrl});
        check({tag, " src1"}, alu_src1_o, v.a);
        lat = 1;
        while (!valid_o && lat < 40) begin
            check({tag, " ready_busy"}, {31'd0, ready_o}, 32'd0);
            @(posedge clk_i); #1;
            lat++;
        end
        check({tag, " latency"}, lat, v.lat);
        check({tag, " result"}, result_o, v.result);
        check({tag, " zero"}, {31'd0, zero_o}, {31'd0, v.zero});
        check({tag, " error"}, {31'd0, error_o}, {31'd0, v.err});
        for (int s = 0; s < v.stall; s++) begin
            @(posedge clk_i); #1;
            check({tag, " stall_valid"}, {31'd0, valid_o}, 32'd1);
            check({tag, " stall_result"}, result_o, v.result);
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        check({tag, " back_idle"}, {31'd0, valid_o}, 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        vec_t        v;
        exp_t        e;
        logic [31:0] held;
        int          pulses;
        logic [5:0]  functs[6];

        vecs[0]  = '{3'b010, 6'b100000, 32'd5, 32'd7, 0, 4'd2, 32'd12, 1'b0, 1'b0, 2};
        vecs[1]  = '{3'b001, 6'b000000, 32'd9, 32'd9, 0, 4'd6, 32'd0, 1'b1, 1'b0, 2};
        vecs[2]  = '{3'b010, 6'b011000, 32'd6, 32'd7, 0, 4'd4, 32'd42, 1'b0, 1'b0, 4};
        vecs[3]  = '{3'b010, 6'b000000, 32'd1, 32'd2, 0, 4'd15, 32'd0, 1'b1, 1'b1, 2};
        vecs[4]  = '{3'b111, 6'b100000, 32'd3, 32'd4, 1, 4'd15, 32'd0, 1'b1, 1'b1, 2};
        vecs[5]  = '{3'b011, 6'b000000, 32'hFFFF_FFFF, 32'd1, 0, 4'd7, 32'd1, 1'b0, 1'b0, 2};
        vecs[6]  = '{3'b010, 6'b100100, 32'h0000_F0F0, 32'h0000_0FF0, 2, 4'd0, 32'h0000_00F0, 1'b0, 1'b0, 2};
        vecs[7]  = '{3'b110, 6'b000000, 32'hDEAD_BEEF, 32'd0, 0, 4'd11, 32'hDEAD_BEEF, 1'b0, 1'b0, 2};
        vecs[8]  = '{3'b100, 6'b000000, 32'h0000_000F, 32'h0000_00F0, 0, 4'd0, 32'd0, 1'b1, 1'b0, 2};
        vecs[9]  = '{3'b010, 6'b100101, 32'd3, 32'd4, 0, 4'd1, 32'd7, 1'b0, 1'b0, 2};
        vecs[10] = '{3'b010, 6'b100010, 32'd3, 32'd5, 3, 4'd6, 32'hFFFF_FFFE, 1'b0, 1'b0, 2};
        vecs[11] = '{3'b010, 6'b101010, 32'd5, 32'd3, 0, 4'd7, 32'd0, 1'b1, 1'b0, 2};

        functs[0] = 6'b100100; functs[1] = 6'b100101; functs[2] = 6'b100000;
        functs[3] = 6'b100010; functs[4] = 6'b101010; functs[5] = 6'b011000;

        // Reset state, observed before the first clock edge.
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        aluop_i = 3'd0; funct_i = 6'd0; src1_i = 32'd0; src2_i = 32'd0;
        #2;
        check("rst ctrl", {28'd0, alu_ctrl_o}, 32'd15);
        check("rst src1", alu_src1_o, 32'd0);
        check("rst src2", alu_src2_o, 32'd0);
        check("rst result", result_o, 32'd0);
        check("rst flags", {29'd0, valid_o, zero_o, error_o}, 32'd0);
        check("rst ready", {31'd0, ready_o}, 32'd1);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Directed vectors.
        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // Backpressure then back-to-back accept with no idle cycle.
        valid_i = 1'b1; aluop_i = 3'b000; src1_i = 32'd5; src2_i = 32'd7; ready_i = 1'b0;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("bp valid", {31'd0, valid_o}, 32'd1);
        held = result_o;
        check("bp result", held, 32'd12);
        for (int s = 0; s < 3; s++) begin
            @(posedge clk_i); #1;
            check("bp hold valid", {31'd0, valid_o}, 32'd1);
            check("bp hold result", result_o, 32'd12);
            check("bp hold ready", {31'd0, ready_o}, 32'd0);
        end
        ready_i = 1'b1; valid_i = 1'b1; aluop_i = 3'b101; src1_i = 32'd3; src2_i = 32'd4;
        #1;
        check("b2b ready", {31'd0, ready_o}, 32'd1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        check("b2b ctrl", {28'd0, alu_ctrl_o}, 32'd1);
        check("b2b in exec", {31'd0, valid_o}, 32'd0);
        @(posedge clk_i); #1;
        check("b2b valid", {31'd0, valid_o}, 32'd1);
        check("b2b result", result_o, 32'd7);
        @(posedge clk_i); #1;

        // Reset asserted during a multiply, when one count remains.
        valid_i = 1'b1; aluop_i = 3'b010; funct_i = 6'b011000; src1_i = 32'd6; src2_i = 32'd7;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        check("mrst ctrl", {28'd0, alu_ctrl_o}, 32'd15);
        check("mrst src", alu_src1_o | alu_src2_o, 32'd0);
        check("mrst result", result_o, 32'd0);
        check("mrst flags", {29'd0, valid_o, zero_o, error_o}, 32'd0);
        pulses = 0;
        for (int s = 0; s < 2; s++) begin
            @(posedge clk_i); #1;
            if (valid_o) pulses++;
        end
        rst_i = 1'b0;
        #1;
        check("mrst ready after release", {31'd0, ready_o}, 32'd1);
        for (int s = 0; s < 6; s++) begin
            @(posedge clk_i); #1;
            if (valid_o) pulses++;
        end
        check("mrst no valid pulse", pulses, 32'd0);

        // Random operations against the reference model.
        for (int n = 0; n < 150; n++) begin
            v.aluop = 3'($urandom);
            v.funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
            v.a     = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            v.b     = ($urandom_range(0, 4) == 0) ? v.a : $urandom;
            v.stall = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            e = model(v.aluop, v.funct, v.a, v.b);
            v.ctrl   = e.ctrl;
            v.result = e.result;
            v.zero   = e.zero;
            v.err    = e.err;
            v.lat    = e.lat;
            run_op(v, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
